param_counter: RTL and testbench
================================

PARAM_COUNTER -- requirements
Module: param_counter

Interface
REQ-001 Parameter WIDTH, default 4: counter width in bits, legal range 2..32.
REQ-002 Parameter MAX, default 15: terminal value; count range is 0..MAX; MAX SHALL satisfy 1 <= MAX <= 2^WIDTH-1.
REQ-003 clk  input  1  global clock; one clock, all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 en  input  1  count enable; one step per cycle while high.
REQ-006 up_dn  input  1  direction, 1 = up, 0 = down.
REQ-007 mode  input  1  boundary mode, 0 = wrap, 1 = saturate.
REQ-008 clr  input  1  synchronous clear to 0.
REQ-009 load  input  1  synchronous parallel load.
REQ-010 load_val  input  WIDTH  value for load.
REQ-011 q  output  WIDTH  registered count value.
REQ-012 tc  output  1  registered terminal-count pulse.
REQ-013 at_max  output  1  combinational flag, q == MAX.
REQ-014 at_zero  output  1  combinational flag, q == 0.

Function
REQ-015 Per-edge priority SHALL be clr > load > en; with none asserted, q holds.
REQ-016 clr SHALL set q to 0 on the next edge and force tc low for that cycle.
REQ-017 load SHALL set q to load_val when load_val <= MAX, otherwise to MAX; tc low for that cycle.
REQ-018 en with up_dn=1 and q < MAX SHALL set q to q+1; en with up_dn=0 and q > 0 SHALL set q to q-1.
REQ-019 Wrap mode, up at MAX: q SHALL become 0; down at 0: q SHALL become MAX.
REQ-020 Saturate mode, up at MAX or down at 0: q SHALL hold.
REQ-021 tc SHALL be 1 for exactly the one cycle after any enabled step taken at the boundary (REQ-019/020 conditions), else 0; consecutive boundary steps in saturate mode SHALL produce tc high on every such cycle.
REQ-022 Latency: q and tc SHALL reflect an input one clock edge after it is sampled; no combinational path from inputs to q or tc.
REQ-023 mode and up_dn SHALL be sampled each cycle; changing them between steps SHALL take effect on the next step with no extra latency.
REQ-024 All next-value arithmetic SHALL be WIDTH bits with explicit boundary compare; no reliance on natural 2^WIDTH overflow when MAX < 2^WIDTH-1.
REQ-025 If q ever holds a value > MAX, the next enabled step SHALL be treated as the boundary case of the current direction.

Reset
REQ-026 rst high SHALL immediately force q = 0 and tc = 0, independent of clk.
REQ-027 While rst is high, clr/load/en SHALL be ignored; first update occurs on the first rising edge after rst falls.
REQ-028 rst asserted mid-count SHALL abort any in-progress tc pulse; at_zero SHALL read 1 during reset.

Structure
REQ-029 Mode encodings (MODE_WRAP=0, MODE_SAT=1) and direction encodings (DIR_DOWN=0, DIR_UP=1) SHALL live in shared package counter_pkg.
REQ-030 Next-value and boundary-detect logic SHALL be a combinational sub-module counter_next (inputs q, controls; outputs q_next, tc_next); param_counter holds only the flip-flops.
REQ-031 Parameter legality (REQ-001/002) SHALL be checked at elaboration with a fatal error.

Verification
REQ-032 WIDTH=4, MAX=9, wrap, up, en for 12 cycles from reset -> q 1..9,0,1,2; tc high only the cycle q shows 0.
REQ-033 WIDTH=4, MAX=9, saturate, down from q=2 for 4 cycles -> q 1,0,0,0; tc high on the last two cycles.
REQ-034 load_val=12 with MAX=9 -> q=9, at_max=1, tc=0; then en up wrap -> q=0, tc=1.
REQ-035 clr, load and en asserted together with q=5 -> q=0, tc=0.
REQ-036 rst pulsed asynchronously between edges while q=7 -> q=0 before next edge, tc=0, at_zero=1; count resumes from 0 after release.
REQ-037 WIDTH=8, MAX=255, wrap, down from 0 -> q=255, tc=1; up from 255 -> q=0, tc=1.

Source files
------------

// File: rtl/counter_pkg.sv
// counter_pkg: shared mode and direction encodings for the counter family
package counter_pkg;

    typedef enum logic {
        MODE_WRAP = 1'b0,
        MODE_SAT  = 1'b1
    } mode_e;

    typedef enum logic {
        DIR_DOWN = 1'b0,
        DIR_UP   = 1'b1
    } dir_e;

endpackage

// File: rtl/counter_next.sv
// counter_next: combinational next-count and terminal-count logic for param_counter
module counter_next
    import counter_pkg::*;
#(
    parameter int unsigned     WIDTH = 4,
    parameter longint unsigned MAX   = 15
) (
    input  logic [WIDTH-1:0] q,
    input  logic             en,
    input  logic             up_dn,
    input  logic             mode,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q_next,
    output logic             tc_next
);
    localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MAX);

    logic             up;
    logic             sat;
    logic             bnd;
    logic [WIDTH-1:0] step_q;
    logic [WIDTH-1:0] load_q;

    // an out-of-range q counts as the boundary in either direction
    always_comb begin
        up      = up_dn == DIR_UP;
        sat     = mode == MODE_SAT;
        bnd     = up ? (q >= MAX_Q) : (q == '0 || q > MAX_Q);
        step_q  = bnd ? (sat ? q : (up ? '0 : MAX_Q)) : (up ? q + WIDTH'(1) : q - WIDTH'(1));
        load_q  = load_val > MAX_Q ? MAX_Q : load_val;
        q_next  = clr ? '0 : load ? load_q : en ? step_q : q;
        tc_next = !clr && !load && en && bnd;
    end
endmodule

// File: rtl/param_counter.sv
// param_counter: up/down wrap-or-saturate counter with clear, load and terminal-count pulse
module param_counter
    import counter_pkg::*;
#(
    parameter int unsigned     WIDTH = 4,
    parameter longint unsigned MAX   = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up_dn,
    input  logic             mode,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             at_max,
    output logic             at_zero
);
    localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MAX);

    if (WIDTH < 2 || WIDTH > 32 || MAX < 1 || MAX > (64'd1 << WIDTH) - 64'd1) begin : g_bad_param
        $fatal(1, "param_counter: illegal WIDTH/MAX combination");
    end

    logic [WIDTH-1:0] q_next;
    logic             tc_next;

    counter_next #(.WIDTH(WIDTH), .MAX(MAX)) u_next (
        .q        (q),
        .en       (en),
        .up_dn    (up_dn),
        .mode     (mode),
        .clr      (clr),
        .load     (load),
        .load_val (load_val),
        .q_next   (q_next),
        .tc_next  (tc_next)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q  <= '0;
            tc <= 1'b0;
        end else begin
            q  <= q_next;
            tc <= tc_next;
        end
    end

    assign at_max  = q == MAX_Q;
    assign at_zero = q == '0;
endmodule

// File: tb/tb_param_counter.sv
// tb_param_counter: table, directed and random checks of param_counter at (4,9) and (8,255)
module tb_param_counter;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b0, up_dn = 1'b1, mode = 1'b0, clr = 1'b0, load = 1'b0;
    logic [7:0] load_val = '0;
    logic [3:0] q4;
    logic [7:0] q8;
    logic       tc4, am4, az4, tc8, am8, az8;

    int n_cmp = 0, n_bad = 0;
    int m4 = 0, m8 = 0;
    bit mtc4 = 0, mtc8 = 0;

    typedef struct {
        bit c, l, e, u, md;
        int lv;
        int eq;
        bit etc;
    } vec_t;

    param_counter #(.WIDTH(4), .MAX(9)) dut4 (
        .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .mode(mode), .clr(clr), .load(load),
        .load_val(load_val[3:0]), .q(q4), .tc(tc4), .at_max(am4), .at_zero(az4)
    );

    param_counter #(.WIDTH(8), .MAX(255)) dut8 (
        .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .mode(mode), .clr(clr), .load(load),
        .load_val(load_val), .q(q8), .tc(tc8), .at_max(am8), .at_zero(az8)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // reference: count range treated as the ring 0..mx, saturation clamps at the ends
    function automatic void mnext(input int mx, input int q, input bit c, l, e, u, md,
                                  input int lv, output int nq, output bit ntc);
        ntc = 0;
        if (c) nq = 0;
        else if (l) nq = lv > mx ? mx : lv;
        else if (e && u) begin
            ntc = q == mx;
            nq  = md ? (q == mx ? q : q + 1) : (q + 1) % (mx + 1);
        end else if (e) begin
            ntc = q == 0;
            nq  = md ? (q == 0 ? 0 : q - 1) : (q + mx) % (mx + 1);
        end else nq = q;
    endfunction

    task automatic drive(input bit c, l, e, u, md, input int lv);
        int n4, n8;
        bit t4, t8;
        clr = c; load = l; en = e; up_dn = u; mode = md; load_val = 8'(lv);
        mnext(9, m4, c, l, e, u, md, lv & 15, n4, t4);
        mnext(255, m8, c, l, e, u, md, lv & 255, n8, t8);
        @(posedge clk);
        #1;
        m4 = n4; mtc4 = t4; m8 = n8; mtc8 = t8;
        chk("q4", q4, m4);
        chk("tc4", tc4, mtc4);
        chk("at_max4", am4, m4 == 9);
        chk("at_zero4", az4, m4 == 0);
        chk("q8", q8, m8);
        chk("tc8", tc8, mtc8);
        chk("at_max8", am8, m8 == 255);
    endtask

    task automatic async_rst(input string tag);
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        chk({tag, "_q4"}, q4, 0);
        chk({tag, "_tc4"}, tc4, 0);
        chk({tag, "_at_zero4"}, az4, 1);
        chk({tag, "_q8"}, q8, 0);
        #1 rst = 1'b0;
        m4 = 0; m8 = 0; mtc4 = 0; mtc8 = 0;
    endtask

    initial begin
        vec_t tbl[12];
        int   expq[12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};
        for (int i = 0; i < 12; i++) tbl[i] = '{0, 0, 1, 1, 0, 0, expq[i], expq[i] == 0};

        #2 rst = 1'b1;
        #1;
        chk("rst_q4", q4, 0);
        chk("rst_tc4", tc4, 0);
        chk("rst_at_zero4", az4, 1);
        en = 1'b1; load = 1'b1; clr = 1'b0; load_val = 8'd5;
        @(posedge clk);
        #1;
        chk("rst_hold_q4", q4, 0);
        chk("rst_hold_q8", q8, 0);
        rst = 1'b0;

        for (int i = 0; i < 12; i++) begin
            drive(tbl[i].c, tbl[i].l, tbl[i].e, tbl[i].u, tbl[i].md, tbl[i].lv);
            chk($sformatf("tbl%0d_q", i), q4, tbl[i].eq);
            chk($sformatf("tbl%0d_tc", i), tc4, tbl[i].etc);
        end

        drive(0, 1, 0, 1, 0, 5);
        chk("load5_q", q4, 5);
        drive(1, 1, 1, 1, 0, 3);
        chk("prio_q", q4, 0);
        chk("prio_tc", tc4, 0);

        drive(0, 1, 0, 0, 1, 2);
        drive(0, 0, 1, 0, 1, 0); chk("sat_dn1_q", q4, 1); chk("sat_dn1_tc", tc4, 0);
        drive(0, 0, 1, 0, 1, 0); chk("sat_dn2_q", q4, 0); chk("sat_dn2_tc", tc4, 0);
        drive(0, 0, 1, 0, 1, 0); chk("sat_dn3_q", q4, 0); chk("sat_dn3_tc", tc4, 1);
        drive(0, 0, 1, 0, 1, 0); chk("sat_dn4_q", q4, 0); chk("sat_dn4_tc", tc4, 1);

        drive(0, 1, 0, 1, 0, 12);
        chk("load12_q", q4, 9); chk("load12_at_max", am4, 1); chk("load12_tc", tc4, 0);
        drive(0, 0, 1, 1, 0, 0);
        chk("wrap_up_q", q4, 0); chk("wrap_up_tc", tc4, 1);

        drive(0, 1, 0, 1, 1, 9);
        drive(0, 0, 1, 1, 1, 0);
        chk("sat_up_tc", tc4, 1);
        async_rst("tc_abort");

        drive(0, 1, 0, 1, 0, 7);
        chk("load7_q", q4, 7);
        async_rst("async");
        drive(0, 0, 1, 1, 0, 0);
        chk("resume_q", q4, 1);

        drive(1, 0, 0, 1, 0, 0);
        drive(0, 0, 1, 0, 0, 0);
        chk("w8_dn_q", q8, 255); chk("w8_dn_tc", tc8, 1);
        drive(0, 0, 1, 1, 0, 0);
        chk("w8_up_q", q8, 0); chk("w8_up_tc", tc8, 1);

        for (int i = 0; i < 400; i++)
            drive($urandom_range(15) == 0, $urandom_range(7) == 0, $urandom_range(3) != 0,
                  1'($urandom), 1'($urandom), int'($urandom_range(255)));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
